ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
Parametrised AHB read-data/response multiplexer. It routes HRDATA, HREADYOUT and HRESP from N slaves back to the master. The slave select is registered at the address phase so that muxing follows the AHB data phase. It contains a built-in default slave that gives the AHB two-cycle ERROR response for transfers to unmapped slave indices. It sits between the address decoder and the master, alongside the interconnect.

Parameters:
NUM_SLAVES, 4, number of attached slaves (1..2^SEL_WIDTH)
DATA_WIDTH, 32, read data width in bits
SEL_WIDTH, 2, width of decoder slave index

Ports:
hClk  input  1  bus clock, all state updates on rising edge
hReset  input  1  asynchronous, active-high reset
hSel  input  SEL_WIDTH  decoded slave index for current address phase
hSelValid  input  1  decoder hit; 0 = address maps to no slave
hTrans  input  2  master HTRANS for current address phase
hRdataAll  input  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
hReadyoutAll  input  NUM_SLAVES  slave HREADYOUT, bit i = slave i
hRespAll  input  NUM_SLAVES  slave HRESP, bit i = slave i (1 = ERROR)
hRdata  output  DATA_WIDTH  muxed read data to master
hReadyout  output  1  muxed HREADY, fed to master and all slaves
hResp  output  1  muxed HRESP
dataSel  output  SEL_WIDTH  registered data-phase slave index (debug)

Behaviour:
- Address-phase capture: on a rising hClk with hReadyout=1, the block registers the following:
  - selReg <= hSel
  - validReg <= hSelValid && (hSel < NUM_SLAVES)
  - activeReg <= hTrans[1] (NONSEQ/SEQ = 1, IDLE/BUSY = 0)
- While hReadyout=0, selReg, validReg and activeReg hold. Address-phase inputs are ignored during wait states.
- dataSel = selReg.
- Mapped data phase (validReg=1): outputs are purely combinational from slave selReg: hRdata, hReadyoutAll[selReg], hRespAll[selReg]. There is zero added latency. Slave wait states and ERROR responses pass through unchanged.
- Unmapped data phase (validReg=0): hRdata = 0. The default-slave FSM drives hReadyout and hResp:
  - DEF_OK: hReadyout=1, hResp=0.
  - DEF_ERR1: hReadyout=0, hResp=1.
  - DEF_ERR2: hReadyout=1, hResp=1.
- FSM transitions:
  - Any state with hReadyout=1 at the clock edge (DEF_OK, DEF_ERR2, or a completing mapped transfer):
    - goes to DEF_ERR1 if the captured phase is unmapped (hSelValid=0 or hSel>=NUM_SLAVES) and active (hTrans[1]=1);
    - otherwise goes to DEF_OK.
  - DEF_ERR1 -> DEF_ERR2, unconditionally.
  - The FSM is ignored while validReg=1.
- Unmapped IDLE/BUSY transfers complete zero-wait OKAY.
- Back-to-back unmapped active transfers repeat ERR1, ERR2, ERR1, ERR2 with no gap.
- Reset (asynchronous, immediate, including mid-transfer or mid-ERROR):
  - selReg=0, validReg=0, activeReg=0, FSM=DEF_OK.
  - Outputs: hRdata=0, hReadyout=1, hResp=0, dataSel=0.
  - Any in-flight transfer is abandoned. The first address phase after reset release is captured on the first edge.
- Slave responses for non-selected slaves never affect outputs.
- No X propagation: out-of-range hSel is treated as unmapped.

Test Plan:
1. Reset, then idle with hTrans=0 -> hReadyout=1, hResp=0, hRdata=0, dataSel=0.
2. NONSEQ hSel=2, hSelValid=1; next cycle slave2 drives 0xCAFE0002 with hReadyoutAll[2]=1 -> hRdata=0xCAFE0002, hResp=0 in the data-phase cycle only; other slaves' data is never seen.
3. hSel=1 phase; slave1 holds hReadyoutAll[1]=0 for 3 cycles while hSel is toggled to 3 -> hReadyout=0 for 3 cycles, dataSel stays 1, then slave1 data is returned.
4. NONSEQ with hSelValid=0 -> next cycle hReadyout=0/hResp=1, following cycle hReadyout=1/hResp=1, hRdata=0. Repeat with hTrans=IDLE -> single-cycle OKAY.
5. NUM_SLAVES=3, SEL_WIDTH=2, NONSEQ hSel=3, hSelValid=1 -> two-cycle ERROR. Mapped slave1 returning hRespAll[1]=1 passes through unchanged.
6. Assert hReset during DEF_ERR1 -> outputs immediately hReadyout=1, hResp=0, hRdata=0. After release, NONSEQ hSel=0 returns slave0 data normally.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB read-data/response mux with built-in default (ERROR) slave
// Slave select is captured in the address phase; outputs follow the data phase.
module ahb_resp_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                             hClk,
  input  logic                             hReset,
  input  logic [SEL_WIDTH-1:0]             hSel,
  input  logic                             hSelValid,
  input  logic [1:0]                       hTrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hRdataAll,
  input  logic [NUM_SLAVES-1:0]            hReadyoutAll,
  input  logic [NUM_SLAVES-1:0]            hRespAll,
  output logic [DATA_WIDTH-1:0]            hRdata,
  output logic                             hReadyout,
  output logic                             hResp,
  output logic [SEL_WIDTH-1:0]             dataSel
);

  typedef enum logic [1:0] {
    DEF_OK   = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_e;

  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic                  active_q, active_d;
  def_state_e            state_q, state_d;

  logic [DATA_WIDTH-1:0] rdata_mux;
  logic                  ready_mux;
  logic                  resp_mux;
  logic                  unused_trans0;

  // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
  assign unused_trans0 = hTrans[0];
  assign dataSel       = sel_q;

  // Loop compare instead of a direct index keeps out-of-range selects from reading X.
  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b1;
    resp_mux  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        rdata_mux = hRdataAll[i*DATA_WIDTH +: DATA_WIDTH];
        ready_mux = hReadyoutAll[i];
        resp_mux  = hRespAll[i];
      end
    end
  end

  always_comb begin
    hRdata    = '0;
    hReadyout = 1'b1;
    hResp     = 1'b0;
    if (valid_q) begin
      hRdata    = rdata_mux;
      hReadyout = ready_mux;
      hResp     = resp_mux;
    end else if (active_q) begin
      case (state_q)
        DEF_ERR1: begin
          hReadyout = 1'b0;
          hResp     = 1'b1;
        end
        DEF_ERR2: begin
          hReadyout = 1'b1;
          hResp     = 1'b1;
        end
        default: begin
          hReadyout = 1'b1;
          hResp     = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel_d    = sel_q;
    valid_d  = valid_q;
    active_d = active_q;
    state_d  = state_q;
    if (state_q == DEF_ERR1) begin
      state_d = DEF_ERR2;
    end else if (hReadyout) begin
      sel_d    = hSel;
      valid_d  = hSelValid && (32'(hSel) < 32'(NUM_SLAVES));
      active_d = hTrans[1];
      state_d  = (!valid_d && active_d) ? DEF_ERR1 : DEF_OK;
    end
  end

  always_ff @(posedge hClk or posedge hReset) begin
    if (hReset) begin
      sel_q    <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      state_q  <= DEF_OK;
    end else begin
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb/tb_ahb_resp_mux.sv - directed table-driven bench for ahb_resp_mux
// Drives #1 after posedge, checks on negedge; second instance covers NUM_SLAVES=3.
module tb_ahb_resp_mux;

  logic        hClk = 1'b0;
  logic        hReset;
  logic [1:0]  hSel;
  logic        hSelValid;
  logic [1:0]  hTrans;

  logic [127:0] rdata_all4;
  logic [3:0]   rdy_all4, resp_all4;
  logic [31:0]  rdata4;
  logic         rdy4, resp4;
  logic [1:0]   dsel4;

  logic [95:0]  rdata_all3;
  logic [2:0]   rdy_all3, resp_all3;
  logic [31:0]  rdata3;
  logic         rdy3, resp3;
  logic [1:0]   dsel3;

  int checks = 0;
  int errors = 0;

  always #5 hClk = ~hClk;

  ahb_resp_mux #(.NUM_SLAVES(4), .DATA_WIDTH(32), .SEL_WIDTH(2)) u4 (
    .hClk(hClk), .hReset(hReset), .hSel(hSel), .hSelValid(hSelValid), .hTrans(hTrans),
    .hRdataAll(rdata_all4), .hReadyoutAll(rdy_all4), .hRespAll(resp_all4),
    .hRdata(rdata4), .hReadyout(rdy4), .hResp(resp4), .dataSel(dsel4)
  );

  ahb_resp_mux #(.NUM_SLAVES(3), .DATA_WIDTH(32), .SEL_WIDTH(2)) u3 (
    .hClk(hClk), .hReset(hReset), .hSel(hSel), .hSelValid(hSelValid), .hTrans(hTrans),
    .hRdataAll(rdata_all3), .hReadyoutAll(rdy_all3), .hRespAll(resp_all3),
    .hRdata(rdata3), .hReadyout(rdy3), .hResp(resp3), .dataSel(dsel3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        sv;
    logic [1:0]  trans;
    logic [3:0]  rdy;
    logic [3:0]  resp;
    logic [31:0] e_rdata;
    logic        e_rdy;
    logic        e_resp;
    logic [1:0]  e_dsel;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [31:0] e_rdata, input logic e_rdy,
                      input logic e_resp, input logic [1:0] e_dsel);
    chk({tag, "_rdata"}, rdata4, e_rdata);
    chk({tag, "_ready"}, 32'(rdy4), 32'(e_rdy));
    chk({tag, "_resp"},  32'(resp4), 32'(e_resp));
    chk({tag, "_dsel"},  32'(dsel4), 32'(e_dsel));
  endtask

  task automatic chk3(input string tag, input logic [31:0] e_rdata, input logic e_rdy,
                      input logic e_resp, input logic [1:0] e_dsel);
    chk({tag, "_rdata"}, rdata3, e_rdata);
    chk({tag, "_ready"}, 32'(rdy3), 32'(e_rdy));
    chk({tag, "_resp"},  32'(resp3), 32'(e_resp));
    chk({tag, "_dsel"},  32'(dsel3), 32'(e_dsel));
  endtask

  task automatic drive(input logic [1:0] sel, input logic sv, input logic [1:0] trans);
    hSel      = sel;
    hSelValid = sv;
    hTrans    = trans;
  endtask

  task automatic next_cycle();
    @(posedge hClk);
    #1;
  endtask

  initial begin
    //          sel   sv    trans  rdy      resp     e_rdata        rdy   resp  dsel
    vecs[0]  = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2'd0};
    vecs[1]  = '{2'd2, 1'b1, 2'd2, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2'd0};
    vecs[2]  = '{2'd0, 1'b0, 2'd0, 4'b0100, 4'b1011, 32'hCAFE0002,  1'b1, 1'b0, 2'd2};
    vecs[3]  = '{2'd1, 1'b1, 2'd2, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2'd0};
    vecs[4]  = '{2'd3, 1'b1, 2'd2, 4'b1101, 4'b0000, 32'hCAFE0001,  1'b0, 1'b0, 2'd1};
    vecs[5]  = '{2'd3, 1'b1, 2'd2, 4'b1101, 4'b0000, 32'hCAFE0001,  1'b0, 1'b0, 2'd1};
    vecs[6]  = '{2'd3, 1'b1, 2'd2, 4'b1101, 4'b0000, 32'hCAFE0001,  1'b0, 1'b0, 2'd1};
    vecs[7]  = '{2'd0, 1'b0, 2'd2, 4'b1111, 4'b0000, 32'hCAFE0001,  1'b1, 1'b0, 2'd1};
    vecs[8]  = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 2'd0};
    vecs[9]  = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 2'd0};
    vecs[10] = '{2'd0, 1'b0, 2'd2, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2'd0};
    vecs[11] = '{2'd0, 1'b0, 2'd2, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 2'd0};
    vecs[12] = '{2'd0, 1'b0, 2'd2, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 2'd0};
    vecs[13] = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 2'd0};
    vecs[14] = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 2'd0};
    vecs[15] = '{2'd1, 1'b1, 2'd2, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2'd0};
    vecs[16] = '{2'd0, 1'b0, 2'd0, 4'b1101, 4'b0010, 32'hCAFE0001,  1'b0, 1'b1, 2'd1};
    vecs[17] = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0010, 32'hCAFE0001,  1'b1, 1'b1, 2'd1};
    vecs[18] = '{2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2'd0};

    rdata_all4 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    rdata_all3 = {32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000};
    rdy_all4   = 4'b1111;
    resp_all4  = 4'b0000;
    rdy_all3   = 3'b111;
    resp_all3  = 3'b000;
    drive(2'd0, 1'b0, 2'd0);

    hReset = 1'b1;
    #12;
    chk4("rst", 32'h0, 1'b1, 1'b0, 2'd0);
    chk3("rst3", 32'h0, 1'b1, 1'b0, 2'd0);
    @(posedge hClk);
    #1 hReset = 1'b0;

    // Main table on the 4-slave instance
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].sel, vecs[i].sv, vecs[i].trans);
      rdy_all4  = vecs[i].rdy;
      resp_all4 = vecs[i].resp;
      @(negedge hClk);
      chk4($sformatf("v%0d", i), vecs[i].e_rdata, vecs[i].e_rdy, vecs[i].e_resp, vecs[i].e_dsel);
      next_cycle();
    end

    // 3-slave instance: hSel=3 is out of range -> two-cycle ERROR
    drive(2'd3, 1'b1, 2'd2);
    @(negedge hClk);
    chk3("u3_addr", 32'h0, 1'b1, 1'b0, 2'd0);
    next_cycle();
    drive(2'd0, 1'b0, 2'd0);
    @(negedge hClk);
    chk3("u3_err1", 32'h0, 1'b0, 1'b1, 2'd3);
    next_cycle();
    drive(2'd1, 1'b1, 2'd2);
    @(negedge hClk);
    chk3("u3_err2", 32'h0, 1'b1, 1'b1, 2'd3);
    next_cycle();
    // Slave1 ERROR passes through unchanged
    drive(2'd0, 1'b0, 2'd0);
    rdy_all3  = 3'b101;
    resp_all3 = 3'b010;
    @(negedge hClk);
    chk3("u3_s1err1", 32'hBEEF0001, 1'b0, 1'b1, 2'd1);
    next_cycle();
    rdy_all3 = 3'b111;
    @(negedge hClk);
    chk3("u3_s1err2", 32'hBEEF0001, 1'b1, 1'b1, 2'd1);
    next_cycle();
    resp_all3 = 3'b000;
    @(negedge hClk);
    chk3("u3_idle", 32'h0, 1'b1, 1'b0, 2'd0);
    next_cycle();

    // Asynchronous reset in the middle of DEF_ERR1
    drive(2'd3, 1'b0, 2'd2);
    next_cycle();
    drive(2'd0, 1'b0, 2'd0);
    @(negedge hClk);
    chk4("pre_rst_err1", 32'h0, 1'b0, 1'b1, 2'd3);
    hReset = 1'b1;
    #1;
    chk4("async_rst", 32'h0, 1'b1, 1'b0, 2'd0);
    @(posedge hClk);
    #1 hReset = 1'b0;
    drive(2'd0, 1'b1, 2'd2);
    next_cycle();
    drive(2'd0, 1'b0, 2'd0);
    @(negedge hClk);
    chk4("post_rst_s0", 32'hCAFE0000, 1'b1, 1'b0, 2'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
